// File: rtl/result_byte_unloader_pkg.sv
// -----------------------------------------------------------------------------
// result_byte_unloader_pkg
// Shared definitions for the result byte unloader:
//   - default result/beat widths and FIFO depth
//   - calc_nbytes(): number of output beats needed to carry one result word
//   - serialiser FSM state encoding (IDLE=0, SEND=1)
// -----------------------------------------------------------------------------
package result_byte_unloader_pkg;

    localparam int DATA_W_DEF = 30;
    localparam int BYTE_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Ceiling division: beats needed to cover data_w bits with byte_w-bit beats.
    function automatic int calc_nbytes(input int data_w, input int byte_w);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// DEPTH x DATA_W synchronous FIFO holding pipeline results awaiting
// serialisation. Head word is presented combinationally on rdata.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (ignored while full)
//   pop             read request (ignored while empty)
//   rdata           head-of-queue word
//   full, empty     registered status flags
//   count           registered number of words held
// -----------------------------------------------------------------------------
module result_fifo
    import result_byte_unloader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_r;
    logic              empty_r;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [CNT_W-1:0]  count_next_s;

    // A push while full is refused even if a pop happens in the same cycle.
    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            empty_r <= (count_next_s == CNT_W'(0));
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/result_byte_unloader.sv
// -----------------------------------------------------------------------------
// result_byte_unloader
// Buffers DATA_W-bit results from the end of the MAC pipeline and returns
// each one as NBYTES beats of BYTE_W bits, LSB first, on a valid/ready stream.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_data      result word offered by the pipeline
//   in_ready              FIFO has room; word taken when in_valid & in_ready
//   out_valid/out_data    current output beat
//   out_last              beat is the final (NBYTES-1) beat of its word
//   out_ready             consumer accepts the beat
//   overflow              sticky: a word was offered while in_ready was 0
//   fifo_count            words currently held in the FIFO
// -----------------------------------------------------------------------------
module result_byte_unloader
    import result_byte_unloader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BYTE_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int NBYTES = calc_nbytes(DATA_W, BYTE_W);
    localparam int SHW    = NBYTES * BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state_r;
    logic [SHW-1:0]    shreg_r;
    logic [CNT_W-1:0]  byte_cnt_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              overflow_r;

    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign push_s = in_valid & ~fifo_full_s;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_s),
        .wdata  (in_data),
        .pop    (pop_s),
        .rdata  (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count)
    );

    // Pop when idle with data waiting, or when the last beat of the current
    // word is taken and another word is queued (back-to-back, no bubble).
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = ~fifo_empty_s;
            ST_SEND: pop_s = out_ready & out_last_r & ~fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Serialiser FSM: loads the head word (zero-extended so pad bits read 0),
    // shifts one beat per accepted transfer and holds everything under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shreg_r     <= '0;
            byte_cnt_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        shreg_r     <= SHW'(head_s);
                        byte_cnt_r  <= '0;
                        out_valid_r <= 1'b1;
                        out_last_r  <= (NBYTES == 1);
                        state_r     <= ST_SEND;
                    end else begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (out_ready && !out_last_r) begin
                        shreg_r    <= shreg_r >> BYTE_W;
                        byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                        out_last_r <= ((byte_cnt_r + CNT_W'(1)) == CNT_W'(NBYTES - 1));
                    end else if (out_ready && !fifo_empty_s) begin
                        shreg_r    <= SHW'(head_s);
                        byte_cnt_r <= '0;
                        out_last_r <= (NBYTES == 1);
                    end else if (out_ready) begin
                        // Clear the datapath so out_data reads 0 while idle.
                        shreg_r     <= '0;
                        byte_cnt_r  <= '0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        shreg_r <= shreg_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    shreg_r     <= '0;
                    byte_cnt_r  <= '0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a word offered while full is dropped; only reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (in_valid && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign in_ready  = ~fifo_full_s;
    assign out_valid = out_valid_r;
    assign out_data  = shreg_r[BYTE_W-1:0];
    assign out_last  = out_last_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_result_byte_unloader.sv
// -----------------------------------------------------------------------------
// tb_result_byte_unloader
// Directed + random bench for result_byte_unloader. Accepted words are split
// into expected beats and queued; every accepted output beat is compared with
// the queue head.
// -----------------------------------------------------------------------------
module tb_result_byte_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [29:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        overflow;
    logic [2:0]  fifo_count;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  exp_q [$];
    logic        exp_ovf  = 1'b0;

    result_byte_unloader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a word: LSB first, pad bits zero, last flag on beat 3.
    task automatic push_exp(input logic [29:0] word);
        logic [31:0] w;
        w = {2'b00, word};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), w[8*i +: 8]});
        end
    endtask

    // Score the handshakes visible now, then advance one clock (negedge to negedge).
    task automatic step();
        logic [8:0] e;
        if (in_valid) begin
            if (in_ready) push_exp(in_data);
            else exp_ovf = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_byte", 32'(out_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[7:0]));
                chk("out_last", 32'(out_last), 32'(e[8]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'h0);
        chk("drain_idle_valid", 32'(out_valid), 32'h0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_out_valid", 32'(out_valid), 32'h1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_out_data",   32'(out_data),   32'h0);
        chk("rst_out_last",   32'(out_last),   32'h0);
        chk("rst_in_ready",   32'(in_ready),   32'h1);
        chk("rst_overflow",   32'(overflow),   32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single word, latency of two edges, LSB-first bytes
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 30'h2ABCDEF1;
        step();
        in_valid = 1'b0;
        chk("t1_not_yet_valid", 32'(out_valid), 32'h0);
        chk("t1_count_one",     32'(fifo_count), 32'h1);
        step();
        chk("t1_latency_valid", 32'(out_valid), 32'h1);
        chk("t1_first_byte",    32'(out_data),  32'hF1);
        drain();

        // 2: two words back-to-back, eight contiguous beats
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 30'h01234567;
        step();
        in_data   = 30'h3FEDCBA9;
        step();
        in_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t2_no_gap", 32'(out_valid), 32'h1);
            step();
        end
        chk("t2_idle_after", 32'(out_valid), 32'h0);
        chk("t2_all_beats",  32'(exp_q.size()), 32'h0);

        // 3: stall mid-word for 10 cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 30'h15A5C3E7;
        step();
        in_valid = 1'b0;
        wait_valid();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t3_hold_valid", 32'(out_valid), 32'h1);
            chk("t3_hold_data",  32'(out_data),  32'(exp_q[0][7:0]));
            chk("t3_hold_last",  32'(out_last),  32'(exp_q[0][8]));
            step();
        end
        drain();

        // 4: backpressure fills FIFO; 6th word dropped, overflow sticky
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 30'(32'h100 * (i + 1) + i);
            chk("t4_in_ready", 32'(in_ready), 32'(i < 5));
            step();
        end
        in_valid = 1'b0;
        chk("t4_overflow",   32'(overflow),   32'h1);
        chk("t4_count_full", 32'(fifo_count), 32'h4);
        chk("t4_not_ready",  32'(in_ready),   32'h0);
        step();
        step();
        chk("t4_overflow_sticky", 32'(overflow), 32'h1);
        drain();
        chk("t4_overflow_after_drain", 32'(overflow), 32'(exp_ovf));

        // 5: async reset while at byte 2 of a word, with another word queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 30'h0A0B0C0D;
        step();
        in_data   = 30'h11223344;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("t5_pre_valid", 32'(out_valid),  32'h1);
        chk("t5_pre_count", 32'(fifo_count), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid",    32'(out_valid),  32'h0);
        chk("t5_rst_count",    32'(fifo_count), 32'h0);
        chk("t5_rst_in_ready", 32'(in_ready),   32'h1);
        chk("t5_rst_overflow", 32'(overflow),   32'h0);
        chk("t5_rst_data",     32'(out_data),   32'h0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 30'h3C5A9655;
        step();
        in_valid = 1'b0;
        wait_valid();
        chk("t5_restart_byte0", 32'(out_data), 32'h55);
        drain();

        // 6: push and pop in the same cycle at count = DEPTH-1
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 30'(32'h0777_0000 + i);
            step();
        end
        in_valid = 1'b0;
        chk("t6_count_three", 32'(fifo_count), 32'h3);
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("t6_at_last", 32'(out_last), 32'h1);
        in_valid = 1'b1;
        in_data  = 30'h2EADBEEF;
        step();
        in_valid = 1'b0;
        chk("t6_count_unchanged", 32'(fifo_count), 32'h3);
        chk("t6_still_valid",     32'(out_valid),  32'h1);
        drain();

        // Random soak
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 30'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("soak_overflow", 32'(overflow), 32'(exp_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
